io_copy_engine: RTL
===================

Name: io_copy_engine

Overview:
- Load/store bus initiator that copies a block of bytes from a source address to a destination address.
- Drives the same en_load/addr_load/data_load and en_store/addr_store/data_store port that the io decoder responds to.
- Sits between control logic and the io/memory responder, so software-free byte moves (e.g. input buffer to output port) go through the normal decode path.
- Forward copy, one byte per two cycles.

Parameters:
ADDR_W, 10, width of addr_load/addr_store and of src/dst addresses
DATA_W, 8, width of the data path
LEN_W, 10, width of the length and count values

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  request a copy; sampled only in IDLE
abort  input  1  terminate the running copy early
src_addr  input  ADDR_W  first source address
dst_addr  input  ADDR_W  first destination address
length  input  LEN_W  number of bytes to copy; 0 is legal
en_load  output  1  load request to responder
addr_load  output  ADDR_W  load address
data_load  input  DATA_W  load data, valid combinationally in the same cycle as en_load
en_store  output  1  store request; responder writes on the rising edge ending the cycle
addr_store  output  ADDR_W  store address
data_store  output  DATA_W  store data
busy  output  1  high whenever state is not IDLE
done  output  1  one-cycle completion pulse
aborted  output  1  valid with done; 1 if the copy ended by abort
count  output  LEN_W  bytes stored so far in the current or last copy

Behaviour:
- Reset (async, rst=1): state=IDLE; all outputs 0; internal src/dst/len/idx/buffer registers 0.
- Reset mid-copy: no further load or store is issued; count is cleared.
- States: IDLE, READ, WRITE, DONE.
- IDLE:
  - start=1 at an edge latches src_addr, dst_addr and length, and clears idx and count.
  - Next state is READ, or DONE if length=0.
  - abort is ignored in IDLE.
- READ:
  - en_load=1, addr_load=(src+idx) mod 2^ADDR_W.
  - data_load is captured into the buffer at the edge ending the cycle.
  - Next state is WRITE. If abort=1 in this cycle, next state is DONE with aborted=1 and no store for this byte.
- WRITE:
  - en_store=1, addr_store=(dst+idx) mod 2^ADDR_W, data_store=buffer.
  - At the edge ending the cycle, idx and count increment.
  - Next state is DONE if idx+1==length, else READ.
  - abort=1 in WRITE does not cancel the current store: the byte is written and counted, then the engine goes to DONE with aborted=1.
- DONE: done=1 for exactly one cycle, aborted holds its value, then IDLE.
- Output rules:
  - en_load and en_store are never both high.
  - When an enable is low, its address and data outputs are driven 0.
- Timing:
  - start sampled at edge 0: first en_load is in cycle 1.
  - For length N, done is high in cycle 2N+1 and busy is high for cycles 1..2N+1.
  - For length 0, done is high in cycle 1.
- start while busy is ignored; the latched parameters never change mid-copy.
- Address arithmetic wraps modulo 2^ADDR_W; it never saturates.
- Overlapping regions are copied strictly ascending, with no hazard protection.
- count holds its final value in IDLE until the next accepted start.
- aborted is cleared on the next accepted start.

Test Plan:
- Basic copy: src=0x010, dst=0x3FC (io output region), len=3, responder returns 0xA1,0xB2,0xC3 -> three en_store cycles with addr_store 0x3FC,0x3FD,0x3FE carrying those bytes; done in cycle 7; count=3; aborted=0.
- Zero length: start with len=0 -> no en_load or en_store; done in cycle 1; count=0; busy high only in cycle 1.
- Wrap: src=0x3FF, dst=0x3FE, len=3 -> addr_load 0x3FF,0x000,0x001 and addr_store 0x3FE,0x3FF,0x000.
- Abort in WRITE of byte 2 (len=5) -> 2 bytes stored, count=2, done and aborted=1 in the next cycle. Abort in READ of byte 2 -> count=1, no second store.
- start pulsed during busy with different parameters -> ignored; original copy completes unchanged.
- rst asserted asynchronously in mid-WRITE of a len=4 copy -> all outputs 0 immediately, no store after reset release; new start with len=1 then completes normally in 3 cycles.

Source files
------------

// File: rtl/io_copy_engine.sv
`default_nettype none
// ============================================================================
// Module   : io_copy_engine
// Purpose  : Load/store bus initiator that moves a block of bytes from a
//            source to a destination address, one byte per two cycles.
// Revision : 1.0 - initial release
// ============================================================================
module io_copy_engine #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              en_load,
  output logic [ADDR_W-1:0] addr_load,
  input  logic [DATA_W-1:0] data_load,
  output logic              en_store,
  output logic [ADDR_W-1:0] addr_store,
  output logic [DATA_W-1:0] data_store,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [LEN_W-1:0]  count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_WRITE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_src;
  logic [ADDR_W-1:0]   r_dst;
  logic [LEN_W-1:0]    r_len;
  logic [LEN_W-1:0]    r_idx;
  logic [DATA_W-1:0]   r_buf;
  logic [LEN_W-1:0]    r_count;
  logic                r_aborted;

  logic [LEN_W-1:0]    w_idx_inc;
  logic                w_last;
  logic [ADDR_W-1:0]   w_idx_addr;

  assign w_idx_inc  = r_idx + LEN_W'(1);
  assign w_last     = (w_idx_inc == r_len);
  // Offset is reduced to address width so src+idx wraps modulo 2^ADDR_W.
  assign w_idx_addr = ADDR_W'(r_idx);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_next = (length == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        w_next = abort ? S_DONE : S_WRITE;
      end
      S_WRITE: begin
        // An abort here still lets the current store complete.
        w_next = (abort || w_last) ? S_DONE : S_READ;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_src     <= '0;
      r_dst     <= '0;
      r_len     <= '0;
      r_idx     <= '0;
      r_buf     <= '0;
      r_count   <= '0;
      r_aborted <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_src     <= src_addr;
            r_dst     <= dst_addr;
            r_len     <= length;
            r_idx     <= '0;
            r_count   <= '0;
            r_aborted <= 1'b0;
          end
        end
        S_READ: begin
          r_buf <= data_load;
          if (abort) begin
            r_aborted <= 1'b1;
          end
        end
        S_WRITE: begin
          r_idx   <= w_idx_inc;
          r_count <= r_count + LEN_W'(1);
          if (abort) begin
            r_aborted <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_comb begin
    en_load    = (r_state == S_READ);
    en_store   = (r_state == S_WRITE);
    addr_load  = '0;
    addr_store = '0;
    data_store = '0;
    if (en_load) begin
      addr_load = r_src + w_idx_addr;
    end
    if (en_store) begin
      addr_store = r_dst + w_idx_addr;
      data_store = r_buf;
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign done    = (r_state == S_DONE);
  assign aborted = r_aborted;
  assign count   = r_count;

endmodule
`default_nettype wire
